// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter: shares one memory port between fetch and MEM.
// Ports: clock/reset; fetch req/addr -> inst/valid; data load/store type,
//   addr, wdata -> rdata/valid; stall_if/stall_mem; m_* memory handshake;
//   bus_error pulse and err_addr from the transaction watchdog.
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic [31:0] if_inst,
    output logic        if_valid,
    input  logic [1:0]  d_load_type,
    input  logic [1:0]  d_store_type,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic [63:0] d_rdata,
    output logic        d_valid,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        m_req,
    output logic        m_we,
    output logic [1:0]  m_size,
    output logic [63:0] m_addr,
    output logic [63:0] m_wdata,
    input  logic [63:0] m_rdata,
    input  logic        m_ack,
    output logic        bus_error,
    output logic [63:0] err_addr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // Counter holds the number of ack-less cycles already spent; the cycle
    // in which it reaches TIMEOUT-1 without ack is the last one allowed.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic          m_req_q, m_req_d;
    logic          m_we_q, m_we_d;
    logic [1:0]    m_size_q, m_size_d;
    logic [63:0]   m_addr_q, m_addr_d;
    logic [63:0]   m_wdata_q, m_wdata_d;
    logic [31:0]   if_inst_q, if_inst_d;
    logic [63:0]   d_rdata_q, d_rdata_d;
    logic          if_valid_q, if_valid_d;
    logic          d_valid_q, d_valid_d;
    logic          bus_error_q, bus_error_d;
    logic [63:0]   err_addr_q, err_addr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic d_active;
    logic d_is_store;
    logic d_elig;
    logic f_elig;

    assign d_active   = (d_load_type != 2'd0) | (d_store_type != 2'd0);
    assign d_is_store = (d_store_type != 2'd0);
    // A requester in its valid cycle still shows the finished request.
    assign d_elig     = d_active & ~d_valid_q;
    assign f_elig     = if_req & ~if_valid_q;

    always_comb begin
        state_d     = state_q;
        m_req_d     = m_req_q;
        m_we_d      = m_we_q;
        m_size_d    = m_size_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        if_inst_d   = if_inst_q;
        d_rdata_d   = d_rdata_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        bus_error_d = 1'b0;
        err_addr_d  = err_addr_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (d_elig) begin
                    state_d   = S_DATA;
                    m_req_d   = 1'b1;
                    m_we_d    = d_is_store;
                    m_size_d  = d_is_store ? d_store_type : d_load_type;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    cnt_d     = '0;
                end else if (f_elig) begin
                    state_d   = S_FETCH;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_size_d  = 2'd2;
                    m_addr_d  = if_addr;
                    m_wdata_d = 64'd0;
                    cnt_d     = '0;
                end
            end
            S_FETCH, S_DATA: begin
                if (m_ack) begin
                    state_d = S_IDLE;
                    m_req_d = 1'b0;
                    if (state_q == S_FETCH) begin
                        if_inst_d  = m_rdata[31:0];
                        if_valid_d = 1'b1;
                    end else begin
                        d_rdata_d = m_we_q ? 64'd0 : m_rdata;
                        d_valid_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_IDLE;
                    m_req_d     = 1'b0;
                    bus_error_d = 1'b1;
                    err_addr_d  = m_addr_q;
                    if (state_q == S_FETCH) begin
                        if_inst_d  = 32'd0;
                        if_valid_d = 1'b1;
                    end else begin
                        d_rdata_d = 64'd0;
                        d_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            m_req_q     <= 1'b0;
            m_we_q      <= 1'b0;
            m_size_q    <= 2'd0;
            m_addr_q    <= 64'd0;
            m_wdata_q   <= 64'd0;
            if_inst_q   <= 32'd0;
            d_rdata_q   <= 64'd0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            bus_error_q <= 1'b0;
            err_addr_q  <= 64'd0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            m_req_q     <= m_req_d;
            m_we_q      <= m_we_d;
            m_size_q    <= m_size_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            if_inst_q   <= if_inst_d;
            d_rdata_q   <= d_rdata_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            bus_error_q <= bus_error_d;
            err_addr_q  <= err_addr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign m_req     = m_req_q;
    assign m_we      = m_we_q;
    assign m_size    = m_size_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign if_inst   = if_inst_q;
    assign d_rdata   = d_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign bus_error = bus_error_q;
    assign err_addr  = err_addr_q;
    assign stall_if  = if_req & ~if_valid_q;
    assign stall_mem = d_active & ~d_valid_q;

endmodule
